// File: rtl/dmem_mmio_pkg.sv
// Shared memory map for the data-side responder: MMIO base, register offsets,
// STATUS bit positions and the address decoder used by dmem_mmio.
package dmem_mmio_pkg;

    localparam logic [31:0] MMIO_BASE  = 32'hFFFF_0000;
    localparam logic [31:0] OFF_CYCLE  = 32'h0000_0000;
    localparam logic [31:0] OFF_TXDATA = 32'h0000_0004;
    localparam logic [31:0] OFF_STATUS = 32'h0000_0008;

    localparam int STATUS_FULL_BIT  = 0;
    localparam int STATUS_EMPTY_BIT = 1;
    localparam int STATUS_OVF_BIT   = 2;
    localparam int STATUS_COUNT_LSB = 3;
    localparam int STATUS_COUNT_MSB = 7;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_CYCLE,
        SEL_TXDATA,
        SEL_STATUS,
        SEL_NONE
    } sel_e;

    // Word-granular decode: the two byte-offset bits never take part.
    function automatic sel_e decode(input logic [31:0] addr);
        logic [31:0] cyc_addr;
        logic [31:0] tx_addr;
        logic [31:0] st_addr;
        cyc_addr = MMIO_BASE + OFF_CYCLE;
        tx_addr  = MMIO_BASE + OFF_TXDATA;
        st_addr  = MMIO_BASE + OFF_STATUS;
        if (!addr[31])
            return SEL_RAM;
        else if (addr[31:2] == cyc_addr[31:2])
            return SEL_CYCLE;
        else if (addr[31:2] == tx_addr[31:2])
            return SEL_TXDATA;
        else if (addr[31:2] == st_addr[31:2])
            return SEL_STATUS;
        else
            return SEL_NONE;
    endfunction

endpackage

// File: rtl/mmio_fifo.sv
// Output FIFO behind the TXDATA register; drops pushes when full unless a pop
// frees a slot on the same edge. Overflow tracking lives in the parent.
module mmio_fifo #(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    // Storage has no reset; only the bookkeeping below is cleared.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + PW'(1);
            if (do_pop)
                rptr <= rptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/dmem_mmio.sv
// Data-memory responder for the single-cycle core: word RAM below 0x80000000,
// cycle counter, TX FIFO and status register in the MMIO window.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   ram [RAM_WORDS];
    logic [AW-1:0] ram_idx;
    sel_e          sel;
    logic [31:0]   cycle;
    logic          overflow;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [4:0]    count_field;
    logic          push_req;
    logic          pop;
    logic          status_wr;
    logic          cycle_clr;
    logic          overflow_event;
    logic [31:0]   status_word;

    assign sel            = decode(aluout);
    assign ram_idx        = aluout[AW+1:2];
    assign push_req       = memwrite && (sel == SEL_TXDATA);
    assign status_wr      = memwrite && (sel == SEL_STATUS);
    assign cycle_clr      = memwrite && (sel == SEL_CYCLE);
    assign pop            = out_valid && out_ready;
    assign overflow_event = push_req && fifo_full && !pop;
    assign out_valid      = !fifo_empty;
    assign count_field    = 5'(fifo_count);

    // RAM keeps its contents through reset but ignores writes while held.
    always_ff @(posedge clk) begin
        if (!reset && memwrite && (sel == SEL_RAM))
            ram[ram_idx] <= writedata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cycle <= '0;
        else if (cycle_clr)
            cycle <= '0;
        else
            cycle <= cycle + 32'd1;
    end

    // A same-edge overflow outranks a STATUS clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            overflow <= 1'b0;
        else if (overflow_event)
            overflow <= 1'b1;
        else if (status_wr)
            overflow <= 1'b0;
    end

    always_comb begin
        status_word = '0;
        status_word[STATUS_FULL_BIT]  = fifo_full;
        status_word[STATUS_EMPTY_BIT] = fifo_empty;
        status_word[STATUS_OVF_BIT]   = overflow;
        status_word[STATUS_COUNT_MSB:STATUS_COUNT_LSB] = count_field;
    end

    always_comb begin
        readdata = '0;
        case (sel)
            SEL_RAM:    readdata = ram[ram_idx];
            SEL_CYCLE:  readdata = cycle;
            SEL_STATUS: readdata = status_word;
            default:    readdata = '0;
        endcase
    end

    mmio_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .wdata (writedata),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: RAM, cycle counter, TX FIFO, STATUS and reset.
module tb_dmem_mmio;

    localparam logic [31:0] A_CYCLE  = 32'hFFFF_0000;
    localparam logic [31:0] A_TX     = 32'hFFFF_0004;
    localparam logic [31:0] A_STATUS = 32'hFFFF_0008;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int checks   = 0;
    int failures = 0;

    dmem_mmio #(
        .RAM_WORDS  (64),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .aluout    (aluout),
        .writedata (writedata),
        .readdata  (readdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] expected, input string tag);
        memwrite = 1'b0;
        aluout   = addr;
        #1;
        check(tag, readdata, expected);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        memwrite  = 1'b1;
        aluout    = addr;
        writedata = data;
        tick();
        memwrite  = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        memwrite  = 1'b0;
        aluout    = '0;
        writedata = '0;
        out_ready = 1'b0;
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        rd(A_STATUS, 32'h02, "reset_status");
        rd(A_CYCLE, 32'd0, "reset_cycle");
        tick();
        tick();
        reset = 1'b0;

        // Cycle counter: ten edges after release, then clear.
        for (int i = 0; i < 10; i++) tick();
        rd(A_CYCLE, 32'd10, "cycle_after_10");
        wr(A_CYCLE, 32'hFFFF_FFFF);
        rd(A_CYCLE, 32'd0, "cycle_cleared");
        tick();
        rd(A_CYCLE, 32'd1, "cycle_one_after_clear");

        // RAM write, aliasing, and read-old-during-write.
        wr(32'h0000_0010, 32'h1234_5678);
        rd(32'h0000_0010, 32'h1234_5678, "ram_read");
        rd(32'h0000_0110, 32'h1234_5678, "ram_alias");
        rd(32'h0000_0013, 32'h1234_5678, "ram_byte_offset_ignored");
        memwrite  = 1'b1;
        aluout    = 32'h0000_0010;
        writedata = 32'hDEAD_BEEF;
        #1;
        check("ram_read_old_same_cycle", readdata, 32'h1234_5678);
        tick();
        memwrite = 1'b0;
        rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_new_value");
        rd(A_TX, 32'd0, "txdata_reads_zero");
        rd(32'hFFFF_000C, 32'd0, "unmapped_reads_zero");

        // Fill the FIFO, overflow it, then drain.
        out_ready = 1'b0;
        wr(A_TX, 32'hA);
        check("push_visible_next_cycle", {31'd0, out_valid}, 32'd1);
        wr(A_TX, 32'hB);
        wr(A_TX, 32'hC);
        wr(A_TX, 32'hD);
        rd(A_STATUS, 32'h21, "status_full");
        wr(A_TX, 32'hE);
        rd(A_STATUS, 32'h25, "status_overflow");
        tick();
        check("head_held_no_ready", out_data, 32'hA);
        out_ready = 1'b1;
        #1;
        check("drain_0", out_data, 32'hA);
        tick();
        check("drain_1", out_data, 32'hB);
        tick();
        check("drain_2", out_data, 32'hC);
        tick();
        check("drain_3", out_data, 32'hD);
        tick();
        check("drained_valid_low", {31'd0, out_valid}, 32'd0);
        rd(A_STATUS, 32'h06, "status_empty_sticky_ovf");

        // STATUS write clears overflow; other MMIO reads zero.
        wr(A_STATUS, 32'h0);
        rd(A_STATUS, 32'h02, "status_ovf_cleared");
        rd(32'hFFFF_0010, 32'd0, "read_ffff0010");

        // Push while full with a same-edge pop: accepted, no overflow.
        out_ready = 1'b0;
        wr(A_TX, 32'h1);
        wr(A_TX, 32'h2);
        wr(A_TX, 32'h3);
        wr(A_TX, 32'h4);
        rd(A_STATUS, 32'h21, "refill_full");
        out_ready = 1'b1;
        wr(A_TX, 32'hF);
        rd(A_STATUS, 32'h21, "full_push_pop_status");
        check("full_push_pop_head", out_data, 32'h2);
        tick();
        check("pp_drain_3", out_data, 32'h3);
        tick();
        check("pp_drain_4", out_data, 32'h4);
        tick();
        check("pp_drain_f", out_data, 32'hF);
        tick();
        check("pp_empty", {31'd0, out_valid}, 32'd0);

        // Reset mid-drain, asserted between clock edges.
        wr(32'h0000_0020, 32'hCAFE_F00D);
        out_ready = 1'b0;
        wr(A_TX, 32'h11);
        wr(A_TX, 32'h22);
        out_ready = 1'b1;
        tick();
        check("mid_drain_head", out_data, 32'h22);
        #2;
        reset = 1'b1;
        #1;
        check("reset_drops_valid", {31'd0, out_valid}, 32'd0);
        rd(A_STATUS, 32'h02, "reset_mid_status");
        rd(32'h0000_0020, 32'hCAFE_F00D, "ram_survives_reset");
        wr(32'h0000_0020, 32'h0000_0BAD);
        rd(32'h0000_0020, 32'hCAFE_F00D, "ram_write_blocked_in_reset");
        #2;
        reset = 1'b0;
        tick();
        rd(A_CYCLE, 32'd1, "cycle_one_after_release");
        check("fifo_discarded", {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
